// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Summary  : Round-robin sharing of one Alu among NUM_REQ requesters, with a
//            one-deep tagged response register. Optional ALU_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 64
`endif

package alu;
    localparam int OP_W = 4;
    typedef logic [OP_W-1:0] op_t;
    localparam op_t OP_ADD  = 4'd0;
    localparam op_t OP_SUB  = 4'd1;
    localparam op_t OP_AND  = 4'd2;
    localparam op_t OP_OR   = 4'd3;
    localparam op_t OP_XOR  = 4'd4;
    localparam op_t OP_SLL  = 4'd5;
    localparam op_t OP_SRL  = 4'd6;
    localparam op_t OP_SRA  = 4'd7;
    localparam op_t OP_SLT  = 4'd8;
    localparam op_t OP_SLTU = 4'd9;
endpackage

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*alu::OP_W-1:0]  req_op,
    input  logic [NUM_REQ-1:0]            req_is_word,
    input  logic [NUM_REQ*`XLEN-1:0]      req_a,
    input  logic [NUM_REQ*`XLEN-1:0]      req_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output alu::op_t                      alu_op,
    output logic                          alu_is_word_op,
    output logic [`XLEN-1:0]              alu_a,
    output logic [`XLEN-1:0]              alu_b,
    input  logic [`XLEN-1:0]              alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [`XLEN-1:0]              rsp_result
);

    localparam logic [ID_W-1:0] C_LAST_RST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q,     rsp_id_d;
    logic [`XLEN-1:0] rsp_result_q, rsp_result_d;

    logic             w_can_issue;
    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant_idx;

    alu::op_t         w_op_arr [NUM_REQ];
    logic [`XLEN-1:0] w_a_arr  [NUM_REQ];
    logic [`XLEN-1:0] w_b_arr  [NUM_REQ];

`ifdef ALU_ARB_LOCK_EN
    logic             lock_active_q, lock_active_d;
    logic [ID_W-1:0]  lock_id_q,     lock_id_d;
`endif

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_op_arr[i] = req_op[i*alu::OP_W +: alu::OP_W];
            assign w_a_arr[i]  = req_a[i*`XLEN +: `XLEN];
            assign w_b_arr[i]  = req_b[i*`XLEN +: `XLEN];
        end
    endgenerate

    assign w_can_issue = !rsp_valid_q || rsp_ready;

    // Idle selection parks on last_grant so the Alu inputs stay quiet.
    always_comb begin : p_grant
        int              idx;
        logic [ID_W-1:0] idx_id;
        w_grant_vld = 1'b0;
        w_grant_idx = last_grant_q;
        idx         = 0;
        idx_id      = '0;
`ifdef ALU_ARB_LOCK_EN
        if (lock_active_q) begin
            if (w_can_issue && req_valid[lock_id_q]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = lock_id_q;
            end
        end else
`endif
        if (w_can_issue) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = int'(last_grant_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                idx_id = ID_W'(idx);
                if (!w_grant_vld && req_valid[idx_id]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = idx_id;
                end
            end
        end
    end

    always_comb begin : p_ready
        req_ready = '0;
        if (w_grant_vld && reset_n) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign alu_op         = w_op_arr[w_grant_idx];
    assign alu_is_word_op = req_is_word[w_grant_idx];
    assign alu_a          = w_a_arr[w_grant_idx];
    assign alu_b          = w_b_arr[w_grant_idx];

    // A grant always implies acceptance, which also covers the drain-and-refill case.
    always_comb begin : p_next
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (w_grant_vld) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = w_grant_idx;
            rsp_result_d = alu_result;
            last_grant_d = w_grant_idx;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    always_comb begin : p_lock_next
        lock_active_d = lock_active_q;
        lock_id_d     = lock_id_q;
        if (w_grant_vld) begin
            lock_active_d = req_lock[w_grant_idx];
            if (req_lock[w_grant_idx]) begin
                lock_id_d = w_grant_idx;
            end
        end else if (lock_active_q && w_can_issue && !req_valid[lock_id_q]) begin
            lock_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_lock_regs
        if (!reset_n) begin
            lock_active_q <= 1'b0;
            lock_id_q     <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_id_q     <= lock_id_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin : p_regs
        if (!reset_n) begin
            last_grant_q <= C_LAST_RST;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Summary  : Directed self-checking bench for alu_arbiter (NUM_REQ=2 and 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 64
`endif

module tb_alu_arbiter;
    import alu::*;

    localparam int XL = `XLEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    // Two-requester instance
    logic [1:0]      req_valid0, req_ready0, req_is_word0;
    logic [7:0]      req_op0;
    logic [2*XL-1:0] req_a0, req_b0;
    op_t             alu_op0;
    logic            alu_w0;
    logic [XL-1:0]   alu_a0, alu_b0, alu_res0, rsp_result0;
    logic            rsp_valid0, rsp_ready0;
    logic [0:0]      rsp_id0;
`ifdef ALU_ARB_LOCK_EN
    logic [1:0]      req_lock0;
`endif

    // Three-requester instance
    logic [2:0]      req_valid1, req_ready1, req_is_word1;
    logic [11:0]     req_op1;
    logic [3*XL-1:0] req_a1, req_b1;
    op_t             alu_op1;
    logic            alu_w1;
    logic [XL-1:0]   alu_a1, alu_b1, alu_res1, rsp_result1;
    logic            rsp_valid1, rsp_ready1;
    logic [1:0]      rsp_id1;

    alu_arbiter #(.NUM_REQ(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op0),
        .req_is_word(req_is_word0), .req_a(req_a0), .req_b(req_b0),
`ifdef ALU_ARB_LOCK_EN
        .req_lock(req_lock0),
`endif
        .alu_op(alu_op0), .alu_is_word_op(alu_w0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_result(alu_res0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_id(rsp_id0), .rsp_result(rsp_result0)
    );

    alu_arbiter #(.NUM_REQ(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
        .req_is_word(req_is_word1), .req_a(req_a1), .req_b(req_b1),
`ifdef ALU_ARB_LOCK_EN
        .req_lock(3'b000),
`endif
        .alu_op(alu_op1), .alu_is_word_op(alu_w1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_result(alu_res1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_id(rsp_id1), .rsp_result(rsp_result1)
    );

    function automatic logic [XL-1:0] alu_f(op_t op, logic w, logic [XL-1:0] a, logic [XL-1:0] b);
        logic [XL-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        if (w) r = {{(XL-32){r[31]}}, r[31:0]};
        return r;
    endfunction

    always_comb alu_res0 = alu_f(alu_op0, alu_w0, alu_a0, alu_b0);
    always_comb alu_res1 = alu_f(alu_op1, alu_w1, alu_a1, alu_b1);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input int i, input op_t op, input logic w, input logic [XL-1:0] a, input logic [XL-1:0] b);
        req_op0[i*4 +: 4]   = op;
        req_is_word0[i]     = w;
        req_a0[i*XL +: XL]  = a;
        req_b0[i*XL +: XL]  = b;
    endtask

    task automatic set1(input int i, input op_t op, input logic [XL-1:0] a, input logic [XL-1:0] b);
        req_op1[i*4 +: 4]   = op;
        req_is_word1[i]     = 1'b0;
        req_a1[i*XL +: XL]  = a;
        req_b1[i*XL +: XL]  = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp0(input string tag, input logic v, input logic id, input logic [XL-1:0] res);
        chk({tag, "_valid"},  64'(rsp_valid0), 64'(v));
        chk({tag, "_id"},     64'(rsp_id0), 64'(id));
        chk({tag, "_result"}, 64'(rsp_result0), 64'(res));
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid0   = 2'b11;
        req_op0      = '0;
        req_is_word0 = '0;
        req_a0       = '0;
        req_b0       = '0;
        rsp_ready0   = 1'b1;
`ifdef ALU_ARB_LOCK_EN
        req_lock0    = 2'b00;
`endif
        req_valid1   = '0;
        req_op1      = '0;
        req_is_word1 = '0;
        req_a1       = '0;
        req_b1       = '0;
        rsp_ready1   = 1'b1;

        // Reset state, ready gated while in reset
        #12;
        chk_rsp0("reset", 1'b0, 1'b0, 64'h0);
        chk("reset_ready", 64'(req_ready0), 64'h0);
        chk("reset_rsp_valid1", 64'(rsp_valid1), 64'h0);

        // Round-robin between ADD and SUB
        set0(0, OP_ADD, 1'b0, 64'd5, 64'd7);
        set0(1, OP_SUB, 1'b0, 64'd10, 64'd3);
        reset_n = 1'b1;
        #1;
        chk("rr_g0", 64'(req_ready0), 64'h1);
        tick;
        chk_rsp0("rr_r0", 1'b1, 1'b0, 64'd12);
        chk("rr_g1", 64'(req_ready0), 64'h2);
        tick;
        chk_rsp0("rr_r1", 1'b1, 1'b1, 64'd7);
        chk("rr_g2", 64'(req_ready0), 64'h1);
        tick;
        chk_rsp0("rr_r2", 1'b1, 1'b0, 64'd12);
        chk("rr_g3", 64'(req_ready0), 64'h2);

        // Backpressure on an XOR response
        req_valid0 = 2'b10;
        set0(1, OP_XOR, 1'b0, 64'hFF, 64'h0F);
        #1;
        chk("bp_g", 64'(req_ready0), 64'h2);
        tick;
        chk_rsp0("bp_r", 1'b1, 1'b1, 64'hF0);
        rsp_ready0 = 1'b0;
        #1;
        chk("bp_ready0", 64'(req_ready0), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk_rsp0("bp_hold", 1'b1, 1'b1, 64'hF0);
            chk("bp_ready", 64'(req_ready0), 64'h0);
        end
        set0(1, OP_AND, 1'b0, 64'hFF, 64'h0F);
        rsp_ready0 = 1'b1;
        #1;
        chk("bp_release_g", 64'(req_ready0), 64'h2);
        tick;
        chk_rsp0("bp_release_r", 1'b1, 1'b1, 64'h0F);

        // Word op passes is_word through
        req_valid0 = 2'b01;
        set0(0, OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1);
        #1;
        chk("word_g", 64'(req_ready0), 64'h1);
        chk("word_flag", 64'(alu_w0), 64'h1);
        tick;
        chk_rsp0("word_r", 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);

        // Drain without accept holds payload
        req_valid0 = 2'b00;
        set0(0, OP_ADD, 1'b0, 64'd5, 64'd7);
        tick;
        chk_rsp0("drain", 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000);

        // Asynchronous reset mid-cycle discards the pending response
        req_valid0 = 2'b01;
        tick;
        chk_rsp0("pre_arst", 1'b1, 1'b0, 64'd12);
        #3;
        reset_n = 1'b0;
        #1;
        chk_rsp0("arst", 1'b0, 1'b0, 64'h0);
        req_valid0 = 2'b11;
        #1;
        chk("arst_ready", 64'(req_ready0), 64'h0);
        reset_n = 1'b1;
        #1;
        chk("arst_tie", 64'(req_ready0), 64'h1);
        tick;
        chk_rsp0("arst_r", 1'b1, 1'b0, 64'd12);
        req_valid0 = 2'b00;
        tick;

        // Three requesters: 0 and 2 alternate, then 1 joins
        set1(0, OP_ADD, 64'h10, 64'h0);
        set1(1, OP_ADD, 64'h20, 64'h0);
        set1(2, OP_ADD, 64'h30, 64'h0);
        req_valid1 = 3'b101;
        #1;
        chk("n3_g0", 64'(req_ready1), 64'h1);
        tick;
        chk("n3_id0", 64'(rsp_id1), 64'd0);
        chk("n3_r0", 64'(rsp_result1), 64'h10);
        chk("n3_g1", 64'(req_ready1), 64'h4);
        tick;
        chk("n3_id1", 64'(rsp_id1), 64'd2);
        chk("n3_r1", 64'(rsp_result1), 64'h30);
        chk("n3_g2", 64'(req_ready1), 64'h1);
        tick;
        chk("n3_id2", 64'(rsp_id1), 64'd0);
        chk("n3_g3", 64'(req_ready1), 64'h4);
        tick;
        chk("n3_id3", 64'(rsp_id1), 64'd2);
        req_valid1 = 3'b111;
        #1;
        chk("n3_g4", 64'(req_ready1), 64'h1);
        tick;
        chk("n3_id4", 64'(rsp_id1), 64'd0);
        chk("n3_g5", 64'(req_ready1), 64'h2);
        tick;
        chk("n3_id5", 64'(rsp_id1), 64'd1);
        chk("n3_r5", 64'(rsp_result1), 64'h20);
        chk("n3_valid", 64'(rsp_valid1), 64'h1);
        req_valid1 = 3'b000;

`ifdef ALU_ARB_LOCK_EN
        // Lock: req0 holds the Alu for three accepts, then one unlocking accept
        req_valid0 = 2'b10;
        tick;
        chk("lk_pre_id", 64'(rsp_id0), 64'd1);
        req_valid0 = 2'b11;
        req_lock0  = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lk_g0", 64'(req_ready0), 64'h1);
            tick;
            chk("lk_id0", 64'(rsp_id0), 64'd0);
        end
        req_lock0 = 2'b00;
        #1;
        chk("lk_unlock_g", 64'(req_ready0), 64'h1);
        tick;
        chk("lk_unlock_id", 64'(rsp_id0), 64'd0);
        chk("lk_g1", 64'(req_ready0), 64'h2);
        tick;
        chk("lk_id1", 64'(rsp_id0), 64'd1);
        req_valid0 = 2'b00;
`endif

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one Alu instance among NUM_REQ requesters, e.g. execute stage, address-generation and CSR read-modify-write paths.
- Each requester uses a valid/ready handshake.
- A round-robin arbiter picks one request per cycle and drives the Alu operand/op inputs combinationally.
- The Alu result is captured into a one-deep response register, tagged with the requester index, so response latency is 1 cycle.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ): width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_op  input  NUM_REQ x alu::op_t  per-requester op, packed; requester i occupies slice i.
- req_is_word  input  NUM_REQ  per-requester word-op flag.
- req_a  input  NUM_REQ*`XLEN  operand a, packed.
- req_b  input  NUM_REQ*`XLEN  operand b, packed.
- alu_op  output  alu::op_t  to Alu op.
- alu_is_word_op  output  1  to Alu is_word_op.
- alu_a  output  `XLEN  to Alu a.
- alu_b  output  `XLEN  to Alu b.
- alu_result  input  `XLEN  from Alu result; combinational in the same cycle.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that issued the response.
- rsp_result  output  `XLEN  registered Alu result.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_result=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has highest priority after reset.
  - lock_active=0.
  - req_ready is combinational and is forced 0 while reset_n is low.
- Issue-allowed condition: can_issue = !rsp_valid || rsp_ready.
- Grant selection (combinational):
  - If can_issue is true, grant the first i with req_valid[i], scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Otherwise there is no grant.
- req_ready:
  - req_ready[i]=1 only for the granted index.
  - The accept condition is req_valid[i] && req_ready[i].
  - req_ready never depends on the requester's own req_ready; there are no combinational loops.
- Alu drive:
  - alu_op, alu_is_word_op, alu_a and alu_b mux the granted slice.
  - When there is no grant, they drive requester last_grant's slice, for stable inputs and low toggle.
  - Downstream ignores alu_* when there is no grant.
- Accept edge:
  - rsp_result<=alu_result, rsp_id<=grant index, rsp_valid<=1, last_grant<=grant index.
- Drain edge without accept (rsp_valid && rsp_ready and no grant): rsp_valid<=0; rsp_result and rsp_id hold.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and rsp_valid stays 1. This gives full throughput of 1 op/cycle.
- Backpressure:
  - While rsp_valid && !rsp_ready, all req_ready=0.
  - rsp_* hold stable.
  - last_grant holds.
- Requester contract: a requester may drop req_valid or change payload before acceptance. The arbiter stores nothing from unaccepted requests.
- Fairness: every continuously valid requester is granted within NUM_REQ accept cycles.
- Word ops: sign-extension is performed inside the Alu; the arbiter passes is_word through unchanged.
- Reset mid-operation: a pending response is discarded; no response is produced for it.

Optional Feature:
- Macro ALU_ARB_LOCK_EN adds the input port req_lock (NUM_REQ bits).
- With the macro defined:
  - An accept from i with req_lock[i]=1 sets lock_active=1 and lock_id=i.
  - While lock_active, grant goes only to lock_id, if req_valid[lock_id]; other requesters wait, and round-robin is bypassed.
  - lock_active clears on an accept with req_lock[lock_id]=0.
  - lock_active also clears on any cycle with can_issue=1 and req_valid[lock_id]=0.
  - last_grant still updates on every accept.
- Without the macro: no req_lock port and no lock state; pure round-robin.

Test Plan:
- Reset, then req_valid=2'b11 held with ops ADD a=5 b=7 (req0) and SUB a=10 b=3 (req1), rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - Responses are id0 result 12, then id1 result 7, on consecutive cycles.
- req1 valid XOR a=0xFF b=0x0F, rsp_ready=0 for 3 cycles.
  - rsp_valid=1, id1, result 0xF0 held for all 3 cycles.
  - req_ready=0 throughout.
  - Raising rsp_ready accepts the next request on that same edge.
- Word op ADD is_word=1, a=0x7FFFFFFF, b=1 -> rsp_result=0xFFFFFFFF80000000.
- NUM_REQ=3, req_valid=3'b101 constant.
  - Grant sequence 0,2,0,2.
  - Then requester 1 raised mid-sequence is granted within 3 accepts.
- Assert reset_n low asynchronously (mid-cycle) while rsp_valid=1 -> rsp_valid=0 immediately; after release requester 0 wins a 2'b11 tie.
- ALU_ARB_LOCK_EN: req0 lock=1 for 3 accepts while req1 is valid.
  - Grants 0,0,0, then 1 after req_lock[0] deasserts on req0's next accepted request.
